// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout
// Description : Pixel framebuffer with a GPU write port and a row-major
//               scanout stream using a valid/ready handshake. Scanout starts
//               on a vsync pulse. The first pixel is presented two cycles
//               later, and after that one pixel per cycle while the sink is
//               ready.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               fb_x/fb_y/fb_color  - GPU write coordinate and colour
//               fb_write            - GPU write strobe (out-of-range dropped)
//               scan_start          - frame start (accepted only when idle)
//               scan_ready          - sink accepts scan_color this cycle
//               scan_valid/color    - scanout pixel stream
//               scan_first/eol      - pixel (0,0) / last pixel of a line
//               swap_request        - back buffer complete
//               swap_pending        - swap requested, not yet performed
// Config      : FRAMEBUFFER_DOUBLE_BUFFER_EN - when defined, there are two
//               planes. The GPU writes the back plane and scanout reads the
//               front plane. The planes swap at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(FB_WIDTH):0]   fb_x,
  input  logic [$clog2(FB_HEIGHT):0]  fb_y,
  input  logic [15:0]                 fb_color,
  input  logic                        fb_write,
  input  logic                        scan_start,
  input  logic                        scan_ready,
  output logic                        scan_valid,
  output logic [15:0]                 scan_color,
  output logic                        scan_first,
  output logic                        scan_eol,
  input  logic                        swap_request,
  output logic                        swap_pending
);

  localparam int c_XW     = $clog2(FB_WIDTH) + 1;
  localparam int c_YW     = $clog2(FB_HEIGHT) + 1;
  localparam int c_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int c_ADDR_W = $clog2(c_DEPTH);

  localparam logic [c_XW-1:0]     c_X_LIMIT    = c_XW'(FB_WIDTH);
  localparam logic [c_YW-1:0]     c_Y_LIMIT    = c_YW'(FB_HEIGHT);
  localparam logic [c_XW-1:0]     c_X_LAST     = c_XW'(FB_WIDTH - 1);
  localparam logic [c_YW-1:0]     c_Y_LAST     = c_YW'(FB_HEIGHT - 1);
  localparam logic [c_ADDR_W-1:0] c_ROW_STRIDE = c_ADDR_W'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                w_accept, w_load, w_done, w_advance;
  logic                r_valid, r_first, r_eol, r_last;
  logic [15:0]         r_color;
  logic [c_ADDR_W-1:0] r_rd_addr;
  logic [c_XW-1:0]     r_rd_x;
  logic [c_YW-1:0]     r_rd_y;

  // The bounds check uses the full port width. The address arithmetic
  // therefore only needs to be correct for in-range coordinates.
  logic                w_wr_en;
  logic [c_ADDR_W-1:0] w_wr_addr;
  assign w_wr_en   = fb_write && (fb_x < c_X_LIMIT) && (fb_y < c_Y_LIMIT);
  assign w_wr_addr = c_ADDR_W'(fb_y) * c_ROW_STRIDE + c_ADDR_W'(fb_x);

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam int c_MEM_AW = c_ADDR_W + 1;
  logic                r_front;
  logic                r_swap_pending;
  logic [c_MEM_AW-1:0] w_wr_mem_addr, w_rd_mem_addr;
  assign w_wr_mem_addr = {~r_front, w_wr_addr};
  assign w_rd_mem_addr = {r_front, r_rd_addr};
  assign swap_pending  = r_swap_pending;

  // The front index toggles on the accept edge, so the FETCH read that
  // follows already addresses the new front plane. A request that arrives
  // in the same cycle as a swap refers to the buffer being swapped now, so
  // it is absorbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_accept && r_swap_pending) begin
      r_front        <= ~r_front;
      r_swap_pending <= 1'b0;
    end else if (swap_request) begin
      r_swap_pending <= 1'b1;
    end
  end
`else
  localparam int c_MEM_AW = c_ADDR_W;
  logic [c_MEM_AW-1:0] w_wr_mem_addr, w_rd_mem_addr;
  logic                w_unused_swap;
  assign w_wr_mem_addr = w_wr_addr;
  assign w_rd_mem_addr = r_rd_addr;
  assign w_unused_swap = swap_request;
  assign swap_pending  = 1'b0;
`endif

  // Pixel storage has no reset, so its contents survive a reset. A read
  // and a write to the same address in one cycle both sample at the same
  // edge, so the read returns the old data.
  logic [15:0] r_mem [0:(1 << c_MEM_AW) - 1];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_mem_addr] <= fb_color;
    end
  end

  assign w_advance = r_valid && scan_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (scan_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_load      = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_advance) begin
          if (r_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The memory read register is also the output register. During a stall
  // no new read is issued, so the presented pixel and its flags hold by
  // themselves. A new read is issued only when the current pixel leaves,
  // which keeps the stream free of bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_color   <= 16'h0000;
      r_first   <= 1'b0;
      r_eol     <= 1'b0;
      r_last    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
    end else if (w_accept) begin
      r_rd_addr <= '0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
    end else if (w_load) begin
      r_color   <= r_mem[w_rd_mem_addr];
      r_valid   <= 1'b1;
      r_first   <= (r_rd_addr == '0);
      r_eol     <= (r_rd_x == c_X_LAST);
      r_last    <= (r_rd_x == c_X_LAST) && (r_rd_y == c_Y_LAST);
      r_rd_addr <= r_rd_addr + 1'b1;
      if (r_rd_x == c_X_LAST) begin
        r_rd_x <= '0;
        r_rd_y <= r_rd_y + 1'b1;
      end else begin
        r_rd_x <= r_rd_x + 1'b1;
      end
    end else if (w_done) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_eol   <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign scan_valid = r_valid;
  assign scan_color = r_color;
  assign scan_first = r_first;
  assign scan_eol   = r_eol;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout
// Description : Self-checking bench for framebuffer_scanout. It uses a 4x2
//               instance and a 10x6 instance. A behavioural model holds the
//               plane contents as plain arrays and predicts every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

  localparam int AW = 4;
  localparam int AH = 2;
  localparam int AN = AW * AH;
  localparam int BW = 10;
  localparam int BH = 6;
  localparam int BN = BW * BH;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_rst, a_wr, a_start, a_ready, a_swap, a_valid, a_first, a_eol, a_pend;
  logic [2:0]  a_x;
  logic [1:0]  a_y;
  logic [15:0] a_wcol, a_scol;
  logic        b_rst, b_wr, b_start, b_ready, b_swap, b_valid, b_first, b_eol, b_pend;
  logic [4:0]  b_x;
  logic [3:0]  b_y;
  logic [15:0] b_wcol, b_scol;

  framebuffer_scanout #(.FB_WIDTH(AW), .FB_HEIGHT(AH)) u_dut_a (
    .clk(clk), .reset(a_rst), .fb_x(a_x), .fb_y(a_y), .fb_color(a_wcol),
    .fb_write(a_wr), .scan_start(a_start), .scan_ready(a_ready),
    .scan_valid(a_valid), .scan_color(a_scol), .scan_first(a_first),
    .scan_eol(a_eol), .swap_request(a_swap), .swap_pending(a_pend)
  );

  framebuffer_scanout #(.FB_WIDTH(BW), .FB_HEIGHT(BH)) u_dut_b (
    .clk(clk), .reset(b_rst), .fb_x(b_x), .fb_y(b_y), .fb_color(b_wcol),
    .fb_write(b_wr), .scan_start(b_start), .scan_ready(b_ready),
    .scan_valid(b_valid), .scan_color(b_scol), .scan_first(b_first),
    .scan_eol(b_eol), .swap_request(b_swap), .swap_pending(b_pend)
  );

  // Reference model: plane contents, front plane index and swap flag.
  logic [15:0] mdl_a [2][AN];
  logic [15:0] mdl_b [2][BN];
  int          front_a = 0;
  int          front_b = 0;
  bit          pend_a  = 1'b0;
  bit          pend_b  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input int x, input int y, input logic [15:0] c);
    a_x = 3'(x); a_y = 2'(y); a_wcol = c; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    if (x < AW && y < AH) mdl_a[DB ? 1 - front_a : 0][y * AW + x] = c;
  endtask

  task automatic write_b(input int x, input int y, input logic [15:0] c);
    b_x = 5'(x); b_y = 4'(y); b_wcol = c; b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    if (x < BW && y < BH) mdl_b[DB ? 1 - front_b : 0][y * BW + x] = c;
  endtask

  task automatic swap_a();
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    if (DB) pend_a = 1'b1;
    check("a_swap_pending", a_pend, pend_a);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random
  // ready plus stray scan_start pulses. abort_at >= 0 applies reset while
  // that pixel is presented. rbw writes pixel (0,0) in the cycle it is
  // fetched.
  task automatic scan_a(input int mode, input int abort_at, input bit rbw, input logic [15:0] rbw_col);
    logic [15:0] exp_f [AN];
    logic [15:0] hc;
    logic        hf, he;
    bit          stalled;
    int          idx, cyc, plane;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    if (DB && pend_a) begin
      front_a = 1 - front_a;
      pend_a  = 1'b0;
    end
    check("a_pending_after_start", a_pend, pend_a);
    plane = DB ? front_a : 0;
    for (int i = 0; i < AN; i++) exp_f[i] = mdl_a[plane][i];
    check("a_latency_cycle1_valid", a_valid, 1'b0);
    if (rbw) begin
      a_x = 3'd0; a_y = 2'd0; a_wcol = rbw_col; a_wr = 1'b1;
    end
    tick();
    a_wr = 1'b0;
    if (rbw) mdl_a[DB ? 1 - front_a : 0][0] = rbw_col;
    check("a_latency_cycle2_valid", a_valid, 1'b1);
    idx = 0; cyc = 0; stalled = 1'b0;
    hc = '0; hf = 1'b0; he = 1'b0;
    while (idx < AN && cyc < 200) begin
      case (mode)
        0:       a_ready = 1'b1;
        1:       a_ready = (cyc % 3 == 0);
        default: a_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) a_start = 1'($urandom_range(0, 1));
      if (stalled) begin
        check("a_hold_color", a_scol, hc);
        check("a_hold_first", a_first, hf);
        check("a_hold_eol", a_eol, he);
      end
      check("a_stream_valid", a_valid, 1'b1);
      if (idx == abort_at) begin
        a_rst = 1'b1; a_start = 1'b0;
        tick();
        check("a_abort_valid", a_valid, 1'b0);
        check("a_abort_first", a_first, 1'b0);
        check("a_abort_eol", a_eol, 1'b0);
        check("a_abort_color", a_scol, 16'h0000);
        check("a_abort_pending", a_pend, 1'b0);
        a_rst = 1'b0; a_ready = 1'b0;
        front_a = 0; pend_a = 1'b0;
        tick();
        return;
      end
      if (a_ready) begin
        check("a_pixel_color", a_scol, exp_f[idx]);
        check("a_pixel_first", a_first, idx == 0);
        check("a_pixel_eol", a_eol, idx % AW == AW - 1);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hc = a_scol; hf = a_first; he = a_eol;
      end
      tick();
      cyc++;
    end
    a_start = 1'b0;
    a_ready = 1'b0;
    if (idx < AN) check("a_frame_timeout", idx, AN);
    check("a_valid_drop_after_last", a_valid, 1'b0);
  endtask

  task automatic scan_b();
    logic [15:0] last_c;
    int          n, cyc, neol, plane;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    if (DB && pend_b) begin
      front_b = 1 - front_b;
      pend_b  = 1'b0;
    end
    plane = DB ? front_b : 0;
    b_ready = 1'b1;
    tick();
    n = 0; cyc = 0; neol = 0; last_c = '0;
    while (b_valid && cyc < BN + 20) begin
      if (n < BN) check("b_pixel_color", b_scol, mdl_b[plane][n]);
      check("b_pixel_first", b_first, n == 0);
      if (b_eol) neol++;
      last_c = b_scol;
      n++;
      tick();
      cyc++;
    end
    b_ready = 1'b0;
    check("b_transfer_count", n, BN);
    check("b_last_pixel", last_c, 16'h1235);
    check("b_eol_count", neol, BH);
  endtask

  initial begin
    a_rst = 1'b1; a_wr = 1'b0; a_start = 1'b0; a_ready = 1'b0; a_swap = 1'b0;
    a_x = '0; a_y = '0; a_wcol = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_start = 1'b0; b_ready = 1'b0; b_swap = 1'b0;
    b_x = '0; b_y = '0; b_wcol = '0;
    tick(); tick(); tick();
    check("rst_valid", a_valid, 1'b0);
    check("rst_first", a_first, 1'b0);
    check("rst_eol", a_eol, 1'b0);
    check("rst_color", a_scol, 16'h0000);
    check("rst_pending", a_pend, 1'b0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // Give every plane defined contents.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < AN; i++) write_a(i % AW, i / AW, 16'h0000);
      swap_a();
      scan_a(0, -1, 1'b0, 16'h0000);
    end

    // Ramp frame, first with ready held high and then with a stall pattern.
    for (int i = 0; i < AN; i++) write_a(i % AW, i / AW, 16'(16'h0001 + 2 * i));
    swap_a();
    scan_a(0, -1, 1'b0, 16'h0000);
    scan_a(1, -1, 1'b0, 16'h0000);

    // Out-of-range writes must be dropped.
    write_a(4, 0, 16'hFFFF);
    write_a(0, 2, 16'hFFFF);
    write_a(7, 3, 16'hFFFF);
    scan_a(0, -1, 1'b0, 16'h0000);

    // A write that lands in the same cycle as the fetch of pixel 0 must
    // leave the fetched pixel unchanged. The next frame shows the new value.
    scan_a(0, -1, 1'b1, 16'h5A5A);
    scan_a(0, -1, 1'b0, 16'h0000);

    // Apply reset mid-frame, then restart.
    scan_a(0, 5, 1'b0, 16'h0000);
    scan_a(0, -1, 1'b0, 16'h0000);

    // Fill with 0x00AA, issue two swap requests, then scan.
    for (int i = 0; i < AN; i++) write_a(i % AW, i / AW, 16'h00AA);
    swap_a();
    swap_a();
    scan_a(0, -1, 1'b0, 16'h0000);

    // Randomised rounds: writes over the full coordinate range, random
    // backpressure and stray scan_start pulses.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++)
        write_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) swap_a();
      scan_a(2, -1, 1'b0, 16'h0000);
    end

    // Non-power-of-two geometry: the corner pixel is last and the transfer
    // count is exact.
    for (int i = 0; i < BN; i++) write_b(i % BW, i / BW, 16'($urandom));
    write_b(BW - 1, BH - 1, 16'h1235);
    write_b(BW, 0, 16'hFFFF);
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    if (DB) pend_b = 1'b1;
    check("b_swap_pending", b_pend, pend_b);
    scan_b();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
